// File: rtl/div_restore_ctrl.sv
// Control and subtract/restore stage of an iterative restoring divider (closes the loop around the external left shifter).
// Optional DIV_ZERO_DETECT_EN: divisor==0 skips the loop and returns all-ones quotient, remainder=dividend.
module div_restore_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic [WIDTH:0]   shifted,
   output logic [WIDTH:0]   acc_out,
   output logic [WIDTH-1:0] quo_out,
   output logic             shift_req_n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SUB, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH:0]   diff;
   logic             zero_div;

`ifdef DIV_ZERO_DETECT_EN
   assign zero_div = (divisor == '0);
`else
   assign zero_div = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      q_d         = q_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      busy_d      = busy_q;
      done_d      = done_q;
      dz_d        = dz_q;
      shift_req_n = 1'b1;
      diff        = shifted - {1'b0, d_q};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (zero_div) begin
                  quot_d  = '1;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  a_d     = '0;
                  q_d     = dividend;
                  d_d     = divisor;
                  cnt_d   = CW'(WIDTH);
                  busy_d  = 1'b1;
                  dz_d    = 1'b0;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            // Shifter captures {A,Q} on this edge; its word is consumed in SUB.
            shift_req_n = 1'b0;
            state_d     = S_SUB;
         end
         S_SUB: begin
            if (!diff[WIDTH]) begin
               a_d = diff;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               a_d = shifted;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quot_d  = q_d;
               rem_d   = a_d[WIDTH-1:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign acc_out     = a_q;
   assign quo_out     = q_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_restore_ctrl.sv
// Bench for div_restore_ctrl: behavioural shifter, cycle-level result model, directed vectors.
module tb_div_restore_ctrl;

   localparam int unsigned W = 16;
`ifdef DIV_ZERO_DETECT_EN
   localparam bit ZD = 1'b1;
`else
   localparam bit ZD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W:0]   shifted;
   logic [W:0]   acc_out;
   logic [W-1:0] quo_out;
   logic         shift_req_n;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int sh_cnt = 0;
   int dn_cnt = 0;

   always #5 clk = ~clk;

   div_restore_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .shifted(shifted), .acc_out(acc_out), .quo_out(quo_out), .shift_req_n(shift_req_n),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   // Upstream left shifter: registers {A[W-1:0], Q[W-1]} when requested.
   always @(posedge clk) begin
      if (rst) shifted <= '0;
      else if (!shift_req_n) shifted <= {acc_out[W-1:0], quo_out[W-1]};
   end

   // Result model: quotient/remainder by plain arithmetic, fixed 2*W cycle latency.
   logic         m_busy = 0, m_done = 0, m_dz = 0, m_zpath = 0;
   logic [W-1:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
   int           m_left = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 0; m_done <= 0; m_dz <= 0; m_zpath <= 0;
         m_q <= '0; m_r <= '0; m_left <= 0;
      end else if (m_done) begin
         m_done <= 0;
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1; m_busy <= 0; m_q <= m_pq; m_r <= m_pr;
         end
      end else if (start) begin
         if (divisor == 0) begin
            m_pq <= '1; m_pr <= dividend;
         end else begin
            m_pq <= dividend / divisor; m_pr <= dividend % divisor;
         end
         if (ZD && divisor == 0) begin
            m_done <= 1; m_q <= '1; m_r <= dividend; m_dz <= 1; m_zpath <= 1;
         end else begin
            m_busy <= 1; m_left <= 2 * W; m_dz <= 0; m_zpath <= 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Shift requests occupy every other cycle of a running division, starting with the first.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         check("shift_req_n", 32'(shift_req_n), 32'(!(m_left != 0 && m_left % 2 == 0)));
         check("quotient", 32'(quotient), 32'(m_q));
         check("remainder", 32'(remainder), 32'(m_r));
         check("div_by_zero", 32'(div_by_zero), 32'(m_dz));
         if (m_done && !m_zpath) begin
            check("acc_final", 32'(acc_out), 32'(m_r));
            check("quo_final", 32'(quo_out), 32'(m_q));
         end
         if (!shift_req_n) sh_cnt++;
         if (done) dn_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // edges counts the accepting edge too: normal path 1 + 2*W, zero-detect path 1.
   task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int exp_edges, input int exp_shifts);
      int edges;
      int sh0;
      sh0 = sh_cnt;
      dividend = a; divisor = b; start = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      while (!done && edges < 100) begin
         tick();
         edges++;
      end
      if (edges >= 100) begin
         total++; bad++;
         $display("FAIL %s_timeout: got no done expected done", name);
      end
      check({name, "_lat"}, 32'(edges), 32'(exp_edges));
      check({name, "_q"}, 32'(quotient), 32'(eq));
      check({name, "_r"}, 32'(remainder), 32'(er));
      check({name, "_model_q"}, 32'(m_q), 32'(eq));
      check({name, "_shifts"}, 32'(sh_cnt - sh0), 32'(exp_shifts));
      tick();
   endtask

   initial begin
      int d0;
      int edges;
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_acc", 32'(acc_out), 0);
      check("rst_quo", 32'(quo_out), 0);
      check("rst_shreq", 32'(shift_req_n), 1);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tick();

      run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 33, 16);
      run_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 33, 16);
      run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 33, 16);
      run_div("d5_10", 16'd5, 16'd10, 16'd0, 16'd5, 33, 16);
      run_div("d0_5", 16'd0, 16'd5, 16'd0, 16'd0, 33, 16);
      run_div("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 33, 16);

      // Re-pulsed start and changed operands mid-run must not disturb 100/7.
      dividend = 16'd100; divisor = 16'd7; start = 1'b1;
      tick();
      start = 1'b0; dividend = 16'd3; divisor = 16'd1;
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 6;
      while (!done && edges < 100) begin
         tick();
         edges++;
      end
      check("repulse_lat", 32'(edges), 33);
      check("repulse_q", 32'(quotient), 14);
      check("repulse_r", 32'(remainder), 2);
      tick();

      // Reset in the middle of a division.
      dividend = 16'd100; divisor = 16'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_q", 32'(quotient), 0);
      check("midrst_r", 32'(remainder), 0);
      check("midrst_acc", 32'(acc_out), 0);
      check("midrst_quo", 32'(quo_out), 0);
      check("midrst_shreq", 32'(shift_req_n), 1);
      d0 = dn_cnt;
      repeat (40) tick();
      check("midrst_nodone", 32'(dn_cnt - d0), 0);
      run_div("after_rst", 16'd100, 16'd7, 16'd14, 16'd2, 33, 16);

      // Zero divisor: short path with detection, raw all-ones/dividend result without.
      if (ZD) begin
         run_div("div0", 16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1, 0);
         check("div0_flag", 32'(div_by_zero), 1);
      end else begin
         run_div("div0", 16'h1234, 16'd0, 16'hFFFF, 16'h1234, 33, 16);
         check("div0_flag", 32'(div_by_zero), 0);
      end
      run_div("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 33, 16);
      check("d9_3_flag", 32'(div_by_zero), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
